// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline register with flush, bubble-zeroed control and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer that registers in_ready.
module pipe_stage_hs #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic [CTRL_W-1:0] out_ctrl_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;

  logic stall;
  logic accept;

  assign stall  = out_valid_reg && !out_ready;
  assign accept = in_valid && in_ready && !flush;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid_reg;
  logic [DATA_W-1:0] skid_data_reg;
  logic [CTRL_W-1:0] skid_ctrl_reg;

  // Ready depends only on skid occupancy; flush forces it high so the flushed beat is consumed.
  assign in_ready = !skid_valid_reg || flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_ctrl_reg   <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_ctrl_reg  <= '0;
    end else if (flush) begin
      out_valid_reg  <= 1'b0;
      out_ctrl_reg   <= '0;
      skid_valid_reg <= 1'b0;
    end else if (!stall) begin
      // Output register is empty or draining: refill, skid entry first to keep order.
      if (skid_valid_reg) begin
        out_valid_reg  <= 1'b1;
        out_data_reg   <= skid_data_reg;
        out_ctrl_reg   <= skid_ctrl_reg;
        skid_valid_reg <= 1'b0;
      end else if (accept) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= in_data;
        out_ctrl_reg  <= in_ctrl;
      end else begin
        out_valid_reg <= 1'b0;
        out_ctrl_reg  <= '0;
      end
    end else if (accept) begin
      skid_valid_reg <= 1'b1;
      skid_data_reg  <= in_data;
      skid_ctrl_reg  <= in_ctrl;
    end
  end
`else
  assign in_ready = !out_valid_reg || out_ready || flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ctrl_reg  <= '0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
      out_ctrl_reg  <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= in_data;
      out_ctrl_reg  <= in_ctrl;
    end else if (!stall) begin
      // Bubble: control goes to zero, data keeps its last value.
      out_valid_reg <= 1'b0;
      out_ctrl_reg  <= '0;
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (clr_cnt) begin
      stall_cnt_reg <= '0;
    end else if (stall && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ctrl  = out_ctrl_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed, table-driven bench for pipe_stage_hs (stall counter built 4 bits wide).
module tb_pipe_stage_hs;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              clr_cnt;
  logic [CNT_W-1:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_hs #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .clr_cnt   (clr_cnt),
    .stall_cnt (stall_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic              iv;
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
    logic              ordy;
    logic              fl;
    logic              clr;
    logic              ir_noskid;
    logic              ir_skid;
    logic              ov;
    logic [DATA_W-1:0] od;
    logic [CTRL_W-1:0] oc;
    logic [CNT_W-1:0]  cnt;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int idx, input logic ov, input logic [DATA_W-1:0] od,
                               input logic [CTRL_W-1:0] oc, input logic [CNT_W-1:0] cnt);
    check({tag, "_out_valid"}, idx, 32'(out_valid), 32'(ov));
    check({tag, "_out_data"},  idx, 32'(out_data),  32'(od));
    check({tag, "_out_ctrl"},  idx, 32'(out_ctrl),  32'(oc));
    check({tag, "_stall_cnt"}, idx, 32'(stall_cnt), 32'(cnt));
  endtask

  task automatic drive(input logic iv, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic ordy, input logic fl, input logic clr);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    clr_cnt   = clr;
  endtask

  initial begin
    //                iv  data     ctrl   ordy fl clr irN irS  ov  out_data  out_ctrl cnt
    vecs[0]  = '{1'b1, 32'h11, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 8'h01, 4'd0};
    vecs[1]  = '{1'b1, 32'h12, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h12, 8'h02, 4'd0};
    vecs[2]  = '{1'b1, 32'h13, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h13, 8'h03, 4'd0};
    vecs[3]  = '{1'b1, 32'h14, 8'h04, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h14, 8'h04, 4'd0};
    vecs[4]  = '{1'b1, 32'h15, 8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h15, 8'h05, 4'd0};
    vecs[5]  = '{1'b0, 32'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h15, 8'h00, 4'd0};
    // back-pressure while holding 0xAA; 0xBB waits (parked in the skid build)
    vecs[6]  = '{1'b1, 32'hAA, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hAA, 8'hAA, 4'd0};
    vecs[7]  = '{1'b1, 32'hBB, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hAA, 8'hAA, 4'd1};
    vecs[8]  = '{1'b1, 32'hBB, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hAA, 8'hAA, 4'd2};
    vecs[9]  = '{1'b1, 32'hBB, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hAA, 8'hAA, 4'd3};
    vecs[10] = '{1'b1, 32'hBB, 8'hBB, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hBB, 8'hBB, 4'd3};
    vecs[11] = '{1'b0, 32'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hBB, 8'h00, 4'd3};
    // flush with a valid 0x5A beat held and 0xCC offered
    vecs[12] = '{1'b1, 32'h5A, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h5A, 8'h5A, 4'd3};
    vecs[13] = '{1'b1, 32'hCC, 8'hCC, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h5A, 8'h00, 4'd4};
    vecs[14] = '{1'b0, 32'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h5A, 8'h00, 4'd4};
    // flush while a second beat waits (skid entry discarded)
    vecs[15] = '{1'b1, 32'hDD, 8'hDD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hDD, 8'hDD, 4'd4};
    vecs[16] = '{1'b1, 32'hEE, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDD, 8'hDD, 4'd5};
    vecs[17] = '{1'b0, 32'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDD, 8'h00, 4'd6};
    vecs[18] = '{1'b0, 32'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDD, 8'h00, 4'd6};
    vecs[19] = '{1'b0, 32'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hDD, 8'h00, 4'd0};

    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #3;
    check_outputs("reset", 0, 1'b0, '0, '0, '0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("reset_in_ready", 0, 32'(in_ready), 32'd1);
    check_outputs("post_reset", 0, 1'b0, '0, '0, '0);

    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      drive(vecs[i].iv, vecs[i].d, vecs[i].c, vecs[i].ordy, vecs[i].fl, vecs[i].clr);
      #1;
      check("in_ready", i, 32'(in_ready), 32'(SKID ? vecs[i].ir_skid : vecs[i].ir_noskid));
      @(posedge clock);
      #1;
      check_outputs("vec", i, vecs[i].ov, vecs[i].od, vecs[i].oc, vecs[i].cnt);
      $display("vec %0d: in %0b/%h out_ready %0b flush %0b -> out_valid %0b data %h ctrl %h stall_cnt %0d",
               i, vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl, out_valid, out_data, out_ctrl, stall_cnt);
    end

    // saturation: load 0x77, then 20 stall cycles
    @(negedge clock);
    drive(1'b1, 32'h77, 8'h77, 1'b1, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    check_outputs("sat_load", 0, 1'b1, 32'h77, 8'h77, 4'd0);
    @(negedge clock);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) @(posedge clock);
    #1;
    check_outputs("sat_20", 0, 1'b1, 32'h77, 8'h77, 4'd15);
    $display("saturate: stall_cnt %0d after 20 stall cycles", stall_cnt);
    @(negedge clock);
    clr_cnt = 1'b1;
    @(posedge clock);
    #1;
    check("sat_clr_priority", 0, 32'(stall_cnt), 32'd0);
    $display("clear: stall_cnt %0d with clr_cnt during stall", stall_cnt);
    @(negedge clock);
    drive(1'b1, 32'h88, 8'h88, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    check_outputs("sat_restart", 0, 1'b1, 32'h77, 8'h77, 4'd1);

    // asynchronous reset between edges while a beat is held
    @(negedge clock);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_outputs("async_reset", 0, 1'b0, '0, '0, '0);
    check("async_reset_in_ready", 0, 32'(in_ready), 32'd1);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    check("release_in_ready", 0, 32'(in_ready), 32'd1);
    check("release_out_valid", 0, 32'(out_valid), 32'd0);
    @(posedge clock);
    #1;
    check_outputs("release_no_beat", 0, 1'b0, '0, '0, '0);
    $display("async reset: out_valid %0b stall_cnt %0d in_ready %0b", out_valid, stall_cnt, in_ready);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
